// File: rtl/apb_setclr_bank_if.sv
// APB slave bus bundle for apb_setclr_bank; AW is the byte-address width.
interface apb_setclr_bank_if #(
  parameter int AW = 6
);
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_setclr_bank.sv
// Bank of NREG set/clear/toggle control registers on APB with programmable wait states.
// Define APB_SETCLR_TOGGLE_EN to decode the +0xC write-1-to-toggle alias.
module apb_setclr_bank #(
  parameter int             NREG    = 4,
  parameter int             DW      = 32,
  parameter int             WAIT    = 0,
  parameter logic [DW-1:0]  RST_VAL = '0,
  parameter int             AW      = $clog2(NREG) + 4
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 enable,
  apb_setclr_bank_if.slave     apb,
  input  logic [NREG*DW-1:0]   hw_set,
  input  logic [NREG*DW-1:0]   hw_clr,
  output logic [NREG*DW-1:0]   ctrl,
  output logic [NREG-1:0]      any_set
);

  localparam int IW = (AW > 4) ? AW - 4 : 1;
  localparam logic [1:0] WAIT_C = 2'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAITING, S_DONE} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic          pready_q;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] nxt  [NREG];
  logic [IW-1:0] idx;
  logic [1:0]    alias_sel;
  logic          err;
  logic          access;
  logic          complete;
  logic          wr_en;
  logic [DW-1:0] rd_val;
  logic          unused_bits;

  if (AW > 4) begin : g_idx
    assign idx = apb.paddr[AW-1:4];
  end else begin : g_noidx
    assign idx = '0;
  end

  assign alias_sel   = apb.paddr[3:2];
  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};
  assign access      = apb.psel & apb.penable;
  assign complete    = access & pready_q;

  always_comb begin
    err = (32'(idx) >= NREG);
`ifndef APB_SETCLR_TOGGLE_EN
    if (alias_sel == 2'd3) err = 1'b1;
`endif
  end

  assign wr_en = complete & apb.pwrite & ~err;

  // Per bit: software op, then hw clear, then hw set, all from the current value.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      nxt[r] = regs[r];
      if (wr_en && (32'(idx) == r)) begin
        case (alias_sel)
          2'd0: nxt[r] = apb.pwdata[DW-1:0];
          2'd1: nxt[r] = regs[r] | apb.pwdata[DW-1:0];
          2'd2: nxt[r] = regs[r] & ~apb.pwdata[DW-1:0];
          default: begin
`ifdef APB_SETCLR_TOGGLE_EN
            nxt[r] = regs[r] ^ apb.pwdata[DW-1:0];
`endif
          end
        endcase
      end
      nxt[r] = (nxt[r] & ~hw_clr[r*DW +: DW]) | hw_set[r*DW +: DW];
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= RST_VAL;
    end else if (enable) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= nxt[r];
    end
  end

  // pready is registered: it reflects the state the counter reached on the previous edge.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pready_q <= (WAIT == 0);
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (access && (WAIT != 0)) begin
            cnt <= 2'd1;
            if (WAIT == 1) begin
              state    <= S_DONE;
              pready_q <= 1'b1;
            end else begin
              state <= S_WAITING;
            end
          end
        end
        S_WAITING: begin
          if (!access) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 2'd1;
            if (cnt + 2'd1 == WAIT_C) begin
              state    <= S_DONE;
              pready_q <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          pready_q <= (WAIT == 0);
        end
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (32'(idx) == r) rd_val = regs[r];
    end
  end

  always_comb begin
    apb.prdata = '0;
    if (complete && !apb.pwrite && !err) apb.prdata[DW-1:0] = rd_val;
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = complete & err;

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      ctrl[r*DW +: DW] = regs[r];
      any_set[r]       = |regs[r];
    end
  end

endmodule

// File: tb/tb_apb_setclr_bank.sv
// Directed self-checking bench for apb_setclr_bank: bank A (WAIT=2, RST_VAL=0xF0), bank B (WAIT=3).
module tb_apb_setclr_bank;

  localparam int AW = 7;

  logic          pclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [AW-1:0] d_addr = '0;
  logic          d_psel = 1'b0;
  logic          d_pen = 1'b0;
  logic          d_wr = 1'b0;
  logic [31:0]   d_wdata = '0;
  logic          use_b = 1'b0;

  logic [127:0]  hw_set_a = '0;
  logic [127:0]  hw_clr_a = '0;
  logic [127:0]  ctrl_a;
  logic [3:0]    any_set_a;
  logic [63:0]   hw_set_b = '0;
  logic [63:0]   hw_clr_b = '0;
  logic [63:0]   ctrl_b;
  logic [1:0]    any_set_b;

  logic [31:0]   m_prdata;
  logic          m_pready;
  logic          m_pslverr;

  int n_pass = 0;
  int n_total = 0;

  always #5 pclk = ~pclk;

  apb_setclr_bank_if #(.AW(AW)) bus_a ();
  apb_setclr_bank_if #(.AW(AW)) bus_b ();

  assign bus_a.paddr   = d_addr;
  assign bus_a.pwrite  = d_wr;
  assign bus_a.pwdata  = d_wdata;
  assign bus_a.psel    = d_psel & ~use_b;
  assign bus_a.penable = d_pen & ~use_b;
  assign bus_b.paddr   = d_addr;
  assign bus_b.pwrite  = d_wr;
  assign bus_b.pwdata  = d_wdata;
  assign bus_b.psel    = d_psel & use_b;
  assign bus_b.penable = d_pen & use_b;

  assign m_prdata  = use_b ? bus_b.prdata  : bus_a.prdata;
  assign m_pready  = use_b ? bus_b.pready  : bus_a.pready;
  assign m_pslverr = use_b ? bus_b.pslverr : bus_a.pslverr;

  apb_setclr_bank #(
    .NREG(4), .DW(32), .WAIT(2), .RST_VAL(32'h0000_00F0), .AW(AW)
  ) u_dut_a (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .apb(bus_a.slave),
    .hw_set(hw_set_a), .hw_clr(hw_clr_a), .ctrl(ctrl_a), .any_set(any_set_a)
  );

  apb_setclr_bank #(
    .NREG(2), .DW(32), .WAIT(3), .RST_VAL(32'h0), .AW(AW)
  ) u_dut_b (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .apb(bus_b.slave),
    .hw_set(hw_set_b), .hw_clr(hw_clr_b), .ctrl(ctrl_b), .any_set(any_set_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One APB transfer; hs/hc are driven onto bank A's hw inputs in the completing cycle only.
  task automatic apb_xfer(input logic [AW-1:0] a, input logic w, input logic [31:0] wd,
                          input logic [127:0] hs, input logic [127:0] hc,
                          output logic [31:0] rd, output logic err, output int waits,
                          output logic leak);
    logic done;
    done  = 1'b0;
    leak  = 1'b0;
    waits = 0;
    rd    = '0;
    err   = 1'b0;
    @(negedge pclk);
    d_addr = a; d_wr = w; d_wdata = wd; d_psel = 1'b1; d_pen = 1'b0;
    #1 if (m_prdata != 0) leak = 1'b1;
    @(negedge pclk);
    d_pen = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      #1;
      if (m_pready) begin
        rd = m_prdata; err = m_pslverr;
        hw_set_a = hs; hw_clr_a = hc;
        done = 1'b1;
      end else begin
        if (m_prdata != 0) leak = 1'b1;
        waits++;
        @(negedge pclk);
      end
    end
    if (!done) check("xfer_timeout", 32'(done), 32'd1);
    @(negedge pclk);
    d_psel = 1'b0; d_pen = 1'b0; hw_set_a = '0; hw_clr_a = '0;
    #1 if (m_prdata != 0) leak = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;
    logic        leak;
    logic [31:0] exp_r1;
    logic [127:0] hs;
    logic [127:0] hc;

    @(negedge pclk);
    #1;
    check("rst_pready_a", 32'(bus_a.pready), 32'd0);
    check("rst_pready_b", 32'(bus_b.pready), 32'd0);
    check("rst_pslverr", 32'(bus_a.pslverr), 32'd0);
    check("rst_prdata", bus_a.prdata, 32'h0);
    check("rst_any_set", 32'(any_set_a), 32'hF);
    check("rst_ctrl_r3", ctrl_a[127:96], 32'h0000_00F0);
    @(negedge pclk);
    reset_n = 1'b1;

    apb_xfer(7'h00, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("wait2_rd_r0", rd, 32'h0000_00F0);
    check("wait2_waits", 32'(waits), 32'd2);
    check("wait2_no_leak", 32'(leak), 32'd0);
    check("wait2_no_err", 32'(err), 32'd0);
    apb_xfer(7'h10, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("rst_rd_r1", rd, 32'h0000_00F0);
    apb_xfer(7'h20, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("rst_rd_r2", rd, 32'h0000_00F0);
    apb_xfer(7'h30, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("rst_rd_r3", rd, 32'h0000_00F0);

    apb_xfer(7'h14, 1'b1, 32'hFFFF_0000, '0, '0, rd, err, waits, leak);
    check("set_r1_ctrl", ctrl_a[63:32], 32'hFFFF_00F0);
    apb_xfer(7'h18, 1'b1, 32'h0F0F_0000, '0, '0, rd, err, waits, leak);
    apb_xfer(7'h14, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("clr_r1_rd", rd, 32'hF0F0_00F0);
    exp_r1 = 32'hF0F0_00F0;

`ifdef APB_SETCLR_TOGGLE_EN
    apb_xfer(7'h1C, 1'b1, 32'h0000_00FF, '0, '0, rd, err, waits, leak);
    check("tog_r1_err", 32'(err), 32'd0);
    apb_xfer(7'h1C, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("tog_r1_rd", rd, 32'hF0F0_000F);
    exp_r1 = 32'hF0F0_000F;
`else
    apb_xfer(7'h0C, 1'b1, 32'h0000_00FF, '0, '0, rd, err, waits, leak);
    check("tog_wr_err", 32'(err), 32'd1);
    check("tog_r0_kept", ctrl_a[31:0], 32'h0000_00F0);
    apb_xfer(7'h0C, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("tog_rd_err", 32'(err), 32'd1);
    check("tog_rd_zero", rd, 32'h0);
`endif

    apb_xfer(7'h40, 1'b1, 32'h1234_5678, '0, '0, rd, err, waits, leak);
    check("oob_wr_err", 32'(err), 32'd1);
    check("oob_r0_kept", ctrl_a[31:0], 32'h0000_00F0);
    check("oob_r1_kept", ctrl_a[63:32], exp_r1);
    apb_xfer(7'h7C, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("oob_rd_err", 32'(err), 32'd1);
    check("oob_rd_zero", rd, 32'h0);

    apb_xfer(7'h20, 1'b1, 32'h0000_0003, '0, '0, rd, err, waits, leak);
    check("direct_r2", ctrl_a[95:64], 32'h0000_0003);
    hs = '0; hc = '0;
    hs[64] = 1'b1;
    hc[65] = 1'b1;
    apb_xfer(7'h28, 1'b1, 32'h0000_0001, hs, hc, rd, err, waits, leak);
    apb_xfer(7'h20, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("sw_hw_merge_r2", rd, 32'h0000_0001);

    @(negedge pclk);
    hw_set_a[104] = 1'b1; hw_clr_a[104] = 1'b1;
    @(negedge pclk);
    hw_set_a = '0; hw_clr_a = '0;
    #1 check("hwset_wins_r3", ctrl_a[127:96], 32'h0000_01F0);

    apb_xfer(7'h38, 1'b1, 32'hFFFF_FFFF, '0, '0, rd, err, waits, leak);
    check("clr_all_any_set", 32'(any_set_a), 32'h7);

    @(negedge pclk);
    enable = 1'b0; hw_set_a[31] = 1'b1;
    d_addr = 7'h00; d_wr = 1'b1; d_wdata = 32'h0; d_psel = 1'b1; d_pen = 1'b0;
    @(negedge pclk);
    d_pen = 1'b1;
    repeat (3) @(negedge pclk);
    #1;
    check("en_lo_pready", 32'(bus_a.pready), 32'd0);
    check("en_lo_r0_hold", ctrl_a[31:0], 32'h0000_00F0);
    d_psel = 1'b0; d_pen = 1'b0; hw_set_a = '0;
    @(negedge pclk);
    enable = 1'b1;
    @(negedge pclk);
    #1 check("en_hi_r0_hold", ctrl_a[31:0], 32'h0000_00F0);
    apb_xfer(7'h00, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("en_hi_waits", 32'(waits), 32'd2);

    use_b = 1'b1;
    @(negedge pclk);
    d_addr = 7'h00; d_wr = 1'b1; d_wdata = 32'h0000_00AA; d_psel = 1'b1; d_pen = 1'b0;
    @(negedge pclk);
    d_pen = 1'b1;
    #1 check("abort_pready_1", 32'(m_pready), 32'd0);
    @(negedge pclk);
    #1 check("abort_pready_2", 32'(m_pready), 32'd0);
    @(negedge pclk);
    d_psel = 1'b0; d_pen = 1'b0;
    @(negedge pclk);
    #1 check("abort_no_write", ctrl_b[31:0], 32'h0);
    apb_xfer(7'h00, 1'b1, 32'h0000_00AA, '0, '0, rd, err, waits, leak);
    check("after_abort_waits", 32'(waits), 32'd3);
    check("after_abort_r0", ctrl_b[31:0], 32'h0000_00AA);
    check("after_abort_any", 32'(any_set_b), 32'h1);
    apb_xfer(7'h04, 1'b0, 32'h0, '0, '0, rd, err, waits, leak);
    check("b_rd_r0", rd, 32'h0000_00AA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
